// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array for sync_fifo: one write port, one registered read port.
// The read register clears on reset; the array itself is never cleared.
module sync_fifo_mem #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and
// one-cycle overflow/underflow pulses on rejected requests.
module sync_fifo #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_push,
    output logic                  w_full,
    input  logic                  r_pop,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_WIDTH = ADDR_WIDTH + 1;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 push_ok, pop_ok;

    // Extra MSB distinguishes full from empty when the low bits match.
    assign r_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
    assign count   = wptr_q - rptr_q;

    always_comb begin
        push_ok     = w_push & ~w_full;
        pop_ok      = r_pop & ~r_empty;
        wptr_d      = wptr_q + PTR_WIDTH'(push_ok);
        rptr_d      = rptr_q + PTR_WIDTH'(pop_ok);
        overflow_d  = w_push & w_full;
        underflow_d = r_pop & r_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Writes are suppressed during reset so a push in the reset cycle leaves no trace.
    sync_fifo_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (push_ok & ~rst),
        .waddr(wptr_q[ADDR_WIDTH-1:0]),
        .wdata(w_data),
        .re   (pop_ok),
        .raddr(rptr_q[ADDR_WIDTH-1:0]),
        .rdata(r_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table for basic handshakes plus
// hand-written fill/drain, concurrent, full/empty edge and mid-reset sequences.
module tb_sync_fifo;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] w_data;
    logic          w_push;
    logic          w_full;
    logic          r_pop;
    logic [DW-1:0] r_data;
    logic          r_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_data   (w_data),
        .w_push   (w_push),
        .w_full   (w_full),
        .r_pop    (r_pop),
        .r_data   (r_data),
        .r_empty  (r_empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] wdata;
        int            exp_count;
        logic          exp_empty;
        logic          exp_full;
        logic          exp_ovf;
        logic          exp_unf;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic push, input logic pop, input logic [DW-1:0] d);
        w_push = push;
        r_pop  = pop;
        w_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        w_push = 1'b0;
        r_pop  = 1'b0;
        w_data = '0;

        // Reset state
        do_reset(2);
        chk("reset_empty", int'(r_empty), 1);
        chk("reset_full", int'(w_full), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_rdata", int'(r_data), 0);
        chk("reset_ovf", int'(overflow), 0);
        chk("reset_unf", int'(underflow), 0);
        $display("txn reset: empty=%0b full=%0b count=%0d", r_empty, w_full, count);

        // push, pop, wdata, count, empty, full, ovf, unf, rdata
        vecs[0] = '{1'b1, 1'b0, 16'h0011, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'h0022, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 16'h0000, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0011};
        vecs[3] = '{1'b1, 1'b1, 16'h0033, 1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0022};
        vecs[4] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0033};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0033};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0033};
        // push+pop while empty: only the push lands, no bypass to r_data
        vecs[7] = '{1'b1, 1'b1, 16'h0044, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0033};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0044};

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].wdata);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d_empty", i), int'(r_empty), int'(vecs[i].exp_empty));
            chk($sformatf("vec%0d_full", i), int'(w_full), int'(vecs[i].exp_full));
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vecs[i].exp_unf));
            chk($sformatf("vec%0d_rdata", i), int'(r_data), int'(vecs[i].exp_rdata));
            $display("txn vec%0d: push=%0b pop=%0b wdata=%h count=%0d rdata=%h",
                     i, vecs[i].push, vecs[i].pop, vecs[i].wdata, count, r_data);
        end

        // Fill with 1..256
        do_reset(1);
        for (int i = 1; i <= 256; i++) begin
            step(1'b1, 1'b0, DW'(i));
            chk("fill_count", int'(count), i);
            chk("fill_full", int'(w_full), (i == 256) ? 1 : 0);
        end
        $display("txn fill: count=%0d full=%0b", count, w_full);

        // Push while full is rejected with a single-cycle pulse
        step(1'b1, 1'b0, DW'(257));
        chk("ovf_pulse", int'(overflow), 1);
        chk("ovf_count", int'(count), 256);
        step(1'b0, 1'b0, '0);
        chk("ovf_clear", int'(overflow), 0);
        $display("txn overflow: count=%0d", count);

        // Drain: must read back 1..256 exactly (257 must not appear)
        for (int i = 1; i <= 256; i++) begin
            step(1'b0, 1'b1, '0);
            chk("drain_rdata", int'(r_data), i);
            chk("drain_count", int'(count), 256 - i);
        end
        chk("drain_empty", int'(r_empty), 1);
        $display("txn drain: last rdata=%0d empty=%0b", r_data, r_empty);

        step(1'b0, 1'b1, '0);
        chk("unf_pulse", int'(underflow), 1);
        chk("unf_rdata", int'(r_data), 256);
        step(1'b0, 1'b0, '0);
        chk("unf_clear", int'(underflow), 0);
        $display("txn underflow: rdata=%0d", r_data);

        // Concurrent push/pop with 10 words stored; 610 pushes wrap the pointers twice
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(i));
        chk("conc_prefill", int'(count), 10);
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'b1, DW'(10 + i));
            chk("conc_rdata", int'(r_data), i);
            chk("conc_count", int'(count), 10);
        end
        $display("txn concurrent: 600 cycles, last rdata=%0d count=%0d", r_data, count);

        // Push+pop while full: only the pop is accepted
        do_reset(1);
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, DW'(1000 + i));
        chk("full_before", int'(w_full), 1);
        step(1'b1, 1'b1, 16'hBEEF);
        chk("full_pp_count", int'(count), 255);
        chk("full_pp_rdata", int'(r_data), 1000);
        chk("full_pp_ovf", int'(overflow), 1);
        chk("full_pp_notfull", int'(w_full), 0);
        $display("txn full push+pop: count=%0d rdata=%0d", count, r_data);

        // Mid-operation reset with 100 words stored
        do_reset(1);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, DW'(i + 7));
        chk("mid_count_before", int'(count), 100);
        do_reset(1);
        chk("mid_empty", int'(r_empty), 1);
        chk("mid_count", int'(count), 0);
        step(1'b1, 1'b0, 16'h00A5);
        step(1'b0, 1'b1, '0);
        chk("mid_rdata", int'(r_data), 'hA5);
        chk("mid_empty_after", int'(r_empty), 1);
        $display("txn mid reset: rdata=%h", r_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO with push/pop handshakes and full/empty status.
- Storage depth is 2^ADDR_WIDTH words of DATA_WIDTH bits, with registered read data.
- Sits between a producer and a consumer in the same clock domain.
- Rejects writes when full and reads when empty, signalling each rejection with a one-cycle error pulse.

Parameters:
- ADDR_WIDTH, 8, address bits; depth DEPTH = 2^ADDR_WIDTH (256 by default).
- DATA_WIDTH, 8, width of each stored word.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- w_data  input  DATA_WIDTH  write data, sampled on an accepted push.
- w_push  input  1  write request.
- w_full  output  1  FIFO holds DEPTH words.
- r_pop  input  1  read request.
- r_data  output  DATA_WIDTH  registered read data.
- r_empty  output  1  FIFO holds 0 words.
- count  output  ADDR_WIDTH+1  number of words currently stored, 0..DEPTH.
- overflow  output  1  one-cycle pulse: push attempted while full.
- underflow  output  1  one-cycle pulse: pop attempted while empty.

Behaviour:
- Reset: rst=1 at a rising edge sets the following, and takes priority over push/pop in the same cycle:
  - write and read pointers = 0, count = 0
  - r_empty = 1, w_full = 0
  - r_data = 0
  - overflow = 0, underflow = 0
- Memory contents are not cleared by reset.
- Acceptance: push_ok = w_push & ~w_full; pop_ok = r_pop & ~r_empty. Both are evaluated on the flag values before the edge.
- Accepted push: mem[wptr] <= w_data; wptr increments, wrapping DEPTH-1 -> 0.
- Accepted pop: r_data <= mem[rptr] at that edge, so data is valid the cycle after pop; rptr increments with wrap.
  - r_data holds its value when no pop is accepted.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - r_empty = (wptr == rptr).
  - w_full = (low bits equal) & (MSBs differ).
  - count = wptr - rptr, modulo 2^(ADDR_WIDTH+1).
- Flags and count are combinational from the registered pointers, so they update in the cycle after the causing edge. No glitch-free registering is required.
- Simultaneous push_ok and pop_ok: both happen and count is unchanged.
  - When the FIFO is empty, pop is rejected and only the push occurs; the pushed word is not bypassed to r_data.
  - When the FIFO is full, push is rejected and only the pop occurs.
- Rejected operations leave pointers, memory and r_data unchanged.
  - overflow <= w_push & w_full, registered: a one-cycle pulse per rejected cycle.
  - underflow <= r_pop & r_empty, registered, same pulse behaviour.
- Ordering: strict first-in first-out across any number of pointer wrap-arounds.
- A reset mid-operation discards all stored words; the FIFO reads as empty on the next cycle.

Decomposition:
- No shared package needed; pointer width (ADDR_WIDTH+1) and DEPTH are local constants derived from parameters.
- One sub-module: sync_fifo_mem, a simple dual-port register array with DEPTH x DATA_WIDTH storage.
  - Write port: we, waddr, wdata.
  - Read port: registered, with re, raddr, rdata.
- Pointer, flag and error logic stays in sync_fifo.

Test Plan:
- Reset: assert rst for 2 cycles, push/pop idle -> r_empty=1, w_full=0, count=0, r_data=0, overflow=underflow=0.
- Fill: push data 1..256 on consecutive cycles -> count reaches 256 and w_full=1 after the 256th push.
  - A 257th push with data 257 -> overflow pulses one cycle, count stays 256, the value is not stored.
- Drain: pop 256 times -> r_data sequence 1..256, each value valid the cycle after its pop; r_empty=1 after the last.
  - An extra pop -> underflow pulses, r_data stays 256.
- Concurrent: with 10 words stored, push and pop together for 600 cycles with incrementing data -> count stays 10, output order is strictly incrementing, pointers wrap at least twice.
- Edge cases: push+pop together when empty -> only the push is accepted, count=1, r_data unchanged.
  - push+pop together when full -> only the pop is accepted, count=255.
- Mid-operation reset: reset asserted with 100 words stored -> next cycle r_empty=1, count=0.
  - A subsequent push of 0xA5 then a pop -> r_data=0xA5.
